// File: rtl/parity_tx_stage.sv
// parity_tx_stage: appends a parity bit to each payload word and forwards it
// downstream through a two-entry skid buffer with a registered grant_o.
module parity_tx_stage #(
   parameter int DATA_WIDTH = 32,
   parameter int EVEN_ODD   = 0,
   parameter int PARITY_BIT = 0,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  corrupt_i,
   input  logic                  valid_i,
   output logic                  grant_o,
   output logic [DATA_WIDTH:0]   data_o,
   output logic                  valid_o,
   input  logic                  grant_i,
   output logic [CNT_WIDTH-1:0]  tx_count_o
);

   localparam logic ODD = 1'(EVEN_ODD);

   typedef enum logic [1:0] {
      EMPTY,
      HALF,
      FULL
   } state_t;

   state_t              state;
   logic [DATA_WIDTH:0] skid;
   logic [DATA_WIDTH:0] word;
   logic                par;
   logic                accept;
   logic                pop;

   assign accept = valid_i & grant_o;
   assign pop    = valid_o & grant_i;
   assign par    = (^data_i) ^ ODD ^ corrupt_i;

   always_comb begin
      if (PARITY_BIT == 0) word = {data_i, par};
      else                 word = {par, data_i};
   end

   // data_o is the main register; skid only fills when downstream stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= EMPTY;
         valid_o    <= 1'b0;
         grant_o    <= 1'b0;
         data_o     <= '0;
         skid       <= '0;
         tx_count_o <= '0;
      end else begin
         if (pop) tx_count_o <= tx_count_o + CNT_WIDTH'(1);
         unique case (state)
            EMPTY: begin
               grant_o <= 1'b1;
               if (accept) begin
                  state   <= HALF;
                  data_o  <= word;
                  valid_o <= 1'b1;
               end
            end
            HALF: begin
               grant_o <= 1'b1;
               if (accept && !pop) begin
                  state   <= FULL;
                  skid    <= word;
                  grant_o <= 1'b0;
               end else if (pop && !accept) begin
                  state   <= EMPTY;
                  valid_o <= 1'b0;
               end else if (accept && pop) begin
                  data_o  <= word;
               end
            end
            FULL: begin
               grant_o <= 1'b0;
               if (pop) begin
                  state   <= HALF;
                  data_o  <= skid;
                  grant_o <= 1'b1;
               end
            end
            default: begin
               state   <= EMPTY;
               valid_o <= 1'b0;
               grant_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_parity_tx_stage.sv
// Bench for parity_tx_stage: scoreboard of accepted words against every pop,
// plus directed checks of reset, parity encoding, backpressure and wrap.
module tb_parity_tx_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] data_i = '0;
   logic        corrupt_i = 1'b0;
   logic        valid_i = 1'b0;
   logic        grant_i = 1'b0;
   logic        grant_o, valid_o;
   logic [32:0] data_o;
   logic [15:0] tx_count_o;
   logic        grant_odd, valid_odd;
   logic [32:0] data_odd;
   logic [15:0] tx_odd;
   logic        grant_c4, valid_c4;
   logic [32:0] data_c4;
   logic [3:0]  tx_c4;

   int checks = 0;
   int errors = 0;
   logic [32:0] q[$];

   always #5 clk = ~clk;

   parity_tx_stage dut (
      .clk(clk), .rst_n(rst_n), .data_i(data_i), .corrupt_i(corrupt_i),
      .valid_i(valid_i), .grant_o(grant_o), .data_o(data_o),
      .valid_o(valid_o), .grant_i(grant_i), .tx_count_o(tx_count_o)
   );

   parity_tx_stage #(.EVEN_ODD(1)) dut_odd (
      .clk(clk), .rst_n(rst_n), .data_i(data_i), .corrupt_i(corrupt_i),
      .valid_i(valid_i), .grant_o(grant_odd), .data_o(data_odd),
      .valid_o(valid_odd), .grant_i(grant_i), .tx_count_o(tx_odd)
   );

   parity_tx_stage #(.CNT_WIDTH(4)) dut_c4 (
      .clk(clk), .rst_n(rst_n), .data_i(data_i), .corrupt_i(corrupt_i),
      .valid_i(valid_i), .grant_o(grant_c4), .data_o(data_c4),
      .valid_o(valid_c4), .grant_i(grant_i), .tx_count_o(tx_c4)
   );

   // inputs change at posedge+1, so negedge sees what the next edge will act on
   always @(negedge clk) begin
      if (rst_n) begin
         if (valid_o && grant_i) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL pop_unexpected got %h want none", data_o);
            end else begin
               logic [32:0] exp;
               exp = q.pop_front();
               if (data_o !== exp) begin
                  errors++;
                  $display("FAIL pop_data got %h want %h", data_o, exp);
               end
            end
         end
         if (valid_i && grant_o)
            q.push_back({data_i, (^data_i) ^ corrupt_i});
      end
   end

   task automatic push_word(input logic [31:0] d, input logic c,
                            output int waited);
      bit done;
      data_i    = d;
      corrupt_i = c;
      valid_i   = 1'b1;
      waited    = 0;
      done      = 0;
      while (!done) begin
         @(negedge clk);
         if (grant_o) done = 1;
         else begin
            waited++;
            if (waited > 200) begin
               checks++;
               errors++;
               $display("FAIL push_timeout got stalled want grant");
               done = 1;
            end
         end
      end
      @(posedge clk);
      #1;
      valid_i   = 1'b0;
      corrupt_i = 1'b0;
   endtask

   task automatic idle(input int n);
      valid_i = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      valid_i = 1'b0;
      #2;
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n = 0;
      grant_i = 1'b1;
      while ((valid_o || q.size() != 0) && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (valid_o || q.size() != 0) begin
         errors++;
         $display("FAIL drain got valid=%0b q=%0d want 0 0", valid_o, q.size());
      end
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if ({valid_o, grant_o, data_o, tx_count_o} !== '0) begin
         errors++;
         $display("FAIL reset_state got v=%b g=%b d=%h c=%h want zeros",
                  valid_o, grant_o, data_o, tx_count_o);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (grant_o !== 1'b0) begin
         errors++;
         $display("FAIL grant_before_edge got %b want 0", grant_o);
      end
      @(posedge clk);
      #1;
      checks++;
      if (grant_o !== 1'b1) begin
         errors++;
         $display("FAIL grant_after_release got %b want 1", grant_o);
      end
   endtask

   task automatic test_parity();
      int w;
      grant_i = 1'b1;
      push_word(32'h3, 1'b0, w);
      checks++;
      if (data_o !== 33'h006 || data_odd !== 33'h007 || valid_o !== 1'b1) begin
         errors++;
         $display("FAIL parity_3 got %h/%h want 006/007", data_o, data_odd);
      end
      push_word(32'h1, 1'b0, w);
      checks++;
      if (data_o !== 33'h003 || data_odd !== 33'h002) begin
         errors++;
         $display("FAIL parity_1 got %h/%h want 003/002", data_o, data_odd);
      end
      push_word(32'h3, 1'b1, w);
      checks++;
      if (data_o !== 33'h007 || data_odd !== 33'h006) begin
         errors++;
         $display("FAIL parity_corrupt got %h/%h want 007/006", data_o, data_odd);
      end
      drain();
   endtask

   task automatic test_reset_mid_full();
      int w;
      grant_i = 1'b0;
      push_word(32'h11, 1'b0, w);
      push_word(32'h22, 1'b0, w);
      checks++;
      if (grant_o !== 1'b0 || valid_o !== 1'b1 || tx_count_o !== 16'd3) begin
         errors++;
         $display("FAIL full_before_reset got g=%b v=%b c=%0d want 0 1 3",
                  grant_o, valid_o, tx_count_o);
      end
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({valid_o, grant_o, data_o, tx_count_o} !== '0) begin
         errors++;
         $display("FAIL reset_mid_full got v=%b g=%b d=%h c=%h want zeros",
                  valid_o, grant_o, data_o, tx_count_o);
      end
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (grant_o !== 1'b1 || valid_o !== 1'b0) begin
         errors++;
         $display("FAIL release_mid_full got g=%b v=%b want 1 0", grant_o, valid_o);
      end
   endtask

   task automatic test_backpressure();
      int w;
      do_reset();
      grant_i = 1'b0;
      push_word(32'hA, 1'b0, w);
      checks++;
      if (grant_o !== 1'b1 || data_o !== 33'h014) begin
         errors++;
         $display("FAIL bp_first got g=%b d=%h want 1 014", grant_o, data_o);
      end
      push_word(32'hB, 1'b0, w);
      checks++;
      if (grant_o !== 1'b0 || data_o !== 33'h014) begin
         errors++;
         $display("FAIL bp_full got g=%b d=%h want 0 014", grant_o, data_o);
      end
      idle(3);
      checks++;
      if (data_o !== 33'h014 || valid_o !== 1'b1 || tx_count_o !== 16'd0) begin
         errors++;
         $display("FAIL bp_hold got d=%h v=%b c=%0d want 014 1 0",
                  data_o, valid_o, tx_count_o);
      end
      grant_i = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (data_o !== 33'h017 || valid_o !== 1'b1 || tx_count_o !== 16'd1) begin
         errors++;
         $display("FAIL bp_pop1 got d=%h v=%b c=%0d want 017 1 1",
                  data_o, valid_o, tx_count_o);
      end
      @(posedge clk);
      #1;
      checks++;
      if (valid_o !== 1'b0 || tx_count_o !== 16'd2 || grant_o !== 1'b1) begin
         errors++;
         $display("FAIL bp_pop2 got v=%b c=%0d g=%b want 0 2 1",
                  valid_o, tx_count_o, grant_o);
      end
   endtask

   task automatic test_throughput();
      int w;
      int stalls = 0;
      do_reset();
      grant_i = 1'b1;
      for (int i = 0; i < 30; i++) begin
         push_word(32'(i), 1'b0, w);
         stalls += w;
      end
      checks++;
      if (stalls != 0 || tx_count_o !== 16'd29) begin
         errors++;
         $display("FAIL throughput got stalls=%0d c=%0d want 0 29",
                  stalls, tx_count_o);
      end
      drain();
      checks++;
      if (tx_count_o !== 16'd30) begin
         errors++;
         $display("FAIL throughput_count got %0d want 30", tx_count_o);
      end
   endtask

   task automatic test_random_stall();
      bit done = 0;
      do_reset();
      fork
         begin
            int w;
            for (int i = 0; i < 1000; i++) begin
               if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 2));
               push_word($urandom, 1'($urandom_range(0, 1)), w);
            end
            done = 1;
         end
         begin
            while (!done) begin
               grant_i = 1'($urandom_range(0, 1));
               @(posedge clk);
               #1;
            end
         end
      join
      drain();
      checks++;
      if (tx_count_o !== 16'd1000) begin
         errors++;
         $display("FAIL random_count got %0d want 1000", tx_count_o);
      end
   endtask

   task automatic test_counter_wrap();
      int w;
      do_reset();
      grant_i = 1'b1;
      for (int i = 0; i < 17; i++) push_word(32'(i * 7), 1'b0, w);
      drain();
      checks++;
      if (tx_c4 !== 4'd1 || tx_count_o !== 16'd17) begin
         errors++;
         $display("FAIL counter_wrap got %0d/%0d want 1/17", tx_c4, tx_count_o);
      end
   endtask

   initial begin
      test_reset();
      test_parity();
      test_reset_mid_full();
      test_backpressure();
      test_throughput();
      test_random_stall();
      test_counter_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
